// File: rtl/psx_ddr_arbiter.sv
// psx_ddr_arbiter: shares the single PSX-to-DDR bridge client port between
// display scan-out (port 0), GPU draw (port 1) and CPU/VRAM transfer (port 2).
// One command is in flight at a time: IDLE -> ISSUE -> WAIT -> IDLE.
// Optional build macro PSX_DDR_ARB_STATS_EN adds per-port grant counters and a
// stall counter (o_grantCnt0/1/2, o_stallCnt).
module psx_ddr_arbiter #(
  parameter int PRIO_PORT0 = 1,
  parameter int CNT_W      = 32
) (
  input  logic         i_clk,
  input  logic         i_nRst,
  input  logic         i_req0,
  input  logic         i_write0,
  input  logic [1:0]   i_size0,
  input  logic [14:0]  i_adr0,
  input  logic [2:0]   i_subadr0,
  input  logic [15:0]  i_mask0,
  input  logic [255:0] i_data0,
  input  logic         i_req1,
  input  logic         i_write1,
  input  logic [1:0]   i_size1,
  input  logic [14:0]  i_adr1,
  input  logic [2:0]   i_subadr1,
  input  logic [15:0]  i_mask1,
  input  logic [255:0] i_data1,
  input  logic         i_req2,
  input  logic         i_write2,
  input  logic [1:0]   i_size2,
  input  logic [14:0]  i_adr2,
  input  logic [2:0]   i_subadr2,
  input  logic [15:0]  i_mask2,
  input  logic [255:0] i_data2,
  output logic         o_ack0,
  output logic         o_ack1,
  output logic         o_ack2,
  output logic         o_dataValid0,
  output logic         o_dataValid1,
  output logic         o_dataValid2,
  output logic [255:0] o_readData,
  output logic         o_command,
  output logic         o_writeElseRead,
  output logic [1:0]   o_commandSize,
  output logic [14:0]  o_targetAddr,
  output logic [2:0]   o_subAddr,
  output logic [15:0]  o_writeMask,
  output logic [255:0] o_dataClient,
`ifdef PSX_DDR_ARB_STATS_EN
  output logic [CNT_W-1:0] o_grantCnt0,
  output logic [CNT_W-1:0] o_grantCnt1,
  output logic [CNT_W-1:0] o_grantCnt2,
  output logic [CNT_W-1:0] o_stallCnt,
`endif
  input  logic         i_busyBridge,
  input  logic         i_dataValidBridge,
  input  logic [255:0] i_dataBridge
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("psx_ddr_arbiter: CNT_W must be at least 1");
  end

  state_e         state_q;
  logic [1:0]     owner_q;
  logic           wr_q;
  logic [1:0]     last_q;      // last granted port feeding the rotation
  logic           cmd_q;
  logic [2:0]     ack_q;
  logic           wel_q;
  logic [1:0]     size_q;
  logic [14:0]    adr_q;
  logic [2:0]     sub_q;
  logic [15:0]    mask_q;
  logic [255:0]   data_q;

  logic [2:0]     req;
  logic           win_vld;
  logic [1:0]     win_idx;
  logic           win_wr;
  logic [1:0]     win_size;
  logic [14:0]    win_adr;
  logic [2:0]     win_sub;
  logic [15:0]    win_mask;
  logic [255:0]   win_data;
  logic           dv_hit;

  assign req = {i_req2, i_req1, i_req0};

  // Winner selection: fixed port-0 priority with 1/2 alternation, or 3-way rotation.
  always_comb begin
    win_vld = |req;
    win_idx = 2'd0;
    if (PRIO_PORT0 != 0) begin
      if (req[0])                win_idx = 2'd0;
      else if (req[1] && req[2]) win_idx = (last_q == 2'd1) ? 2'd2 : 2'd1;
      else if (req[1])           win_idx = 2'd1;
      else                       win_idx = 2'd2;
    end else begin
      case (last_q)
        2'd0:    win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
        2'd1:    win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
        default: win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
    end
  end

  // Field mux for the selected requester.
  always_comb begin
    win_wr = i_write0; win_size = i_size0; win_adr = i_adr0;
    win_sub = i_subadr0; win_mask = i_mask0; win_data = i_data0;
    case (win_idx)
      2'd1: begin
        win_wr = i_write1; win_size = i_size1; win_adr = i_adr1;
        win_sub = i_subadr1; win_mask = i_mask1; win_data = i_data1;
      end
      2'd2: begin
        win_wr = i_write2; win_size = i_size2; win_adr = i_adr2;
        win_sub = i_subadr2; win_mask = i_mask2; win_data = i_data2;
      end
      default: ;
    endcase
  end

  // Command FSM; command strobe and acks are one-cycle registered pulses.
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      wr_q    <= 1'b0;
      last_q  <= 2'd2;   // makes port 1 (or port 0 in full rotation) preferred first
      cmd_q   <= 1'b0;
      ack_q   <= 3'b000;
      wel_q   <= 1'b0;
      size_q  <= 2'd0;
      adr_q   <= 15'd0;
      sub_q   <= 3'd0;
      mask_q  <= 16'd0;
      data_q  <= 256'd0;
    end else begin
      cmd_q <= 1'b0;
      ack_q <= 3'b000;
      case (state_q)
        S_IDLE: begin
          if (win_vld && !i_busyBridge) begin
            cmd_q   <= 1'b1;
            ack_q   <= 3'b001 << win_idx;
            wel_q   <= win_wr;
            size_q  <= win_size;
            adr_q   <= win_adr;
            sub_q   <= win_sub;
            mask_q  <= win_mask;
            data_q  <= win_data;
            owner_q <= win_idx;
            wr_q    <= win_wr;
            // port 0 grants leave the 1/2 alternation untouched in priority mode
            if (PRIO_PORT0 == 0 || win_idx != 2'd0) last_q <= win_idx;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT:  if (!i_busyBridge) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read data-valid goes straight through to the owner while waiting on a read.
  assign dv_hit       = (state_q == S_WAIT) && !wr_q && i_dataValidBridge;
  assign o_dataValid0 = dv_hit && (owner_q == 2'd0);
  assign o_dataValid1 = dv_hit && (owner_q == 2'd1);
  assign o_dataValid2 = dv_hit && (owner_q == 2'd2);
  assign o_readData   = i_dataBridge;

  assign o_ack0          = ack_q[0];
  assign o_ack1          = ack_q[1];
  assign o_ack2          = ack_q[2];
  assign o_command       = cmd_q;
  assign o_writeElseRead = wel_q;
  assign o_commandSize   = size_q;
  assign o_targetAddr    = adr_q;
  assign o_subAddr       = sub_q;
  assign o_writeMask     = mask_q;
  assign o_dataClient    = data_q;

`ifdef PSX_DDR_ARB_STATS_EN
  logic [CNT_W-1:0] gcnt0_q, gcnt1_q, gcnt2_q, stall_q;

  // Statistics: grants per port, and cycles with a pending request but no ack.
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      gcnt2_q <= '0;
      stall_q <= '0;
    end else begin
      if (ack_q[0]) gcnt0_q <= gcnt0_q + CNT_W'(1);
      if (ack_q[1]) gcnt1_q <= gcnt1_q + CNT_W'(1);
      if (ack_q[2]) gcnt2_q <= gcnt2_q + CNT_W'(1);
      if ((|req) && !(|ack_q)) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign o_grantCnt0 = gcnt0_q;
  assign o_grantCnt1 = gcnt1_q;
  assign o_grantCnt2 = gcnt2_q;
  assign o_stallCnt  = stall_q;
`endif

endmodule

// File: tb/tb_psx_ddr_arbiter.sv
// Directed bench for psx_ddr_arbiter: one instance with port-0 priority and one
// with full rotation share all stimulus; bridge behaviour is driven by hand.
module tb_psx_ddr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0]   req, wr;
  logic [1:0]   sz  [3];
  logic [14:0]  adr [3];
  logic [2:0]   sub [3];
  logic [15:0]  msk [3];
  logic [255:0] dat [3];
  logic         busy, dvb;
  logic [255:0] dbr;

  logic ack0, ack1, ack2, dv0, dv1, dv2, cmd, wer;
  logic [255:0] rdata, dcl;
  logic [1:0] csz; logic [14:0] taddr; logic [2:0] saddr; logic [15:0] wmask;
  logic r_ack0, r_ack1, r_ack2, r_dv0, r_dv1, r_dv2, r_cmd, r_wer;
  logic [255:0] r_rdata, r_dcl;
  logic [1:0] r_csz; logic [14:0] r_taddr; logic [2:0] r_saddr; logic [15:0] r_wmask;
`ifdef PSX_DDR_ARB_STATS_EN
  logic [31:0] g0, g1, g2, stall, r_g0, r_g1, r_g2, r_stall;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int p, lat;
  int got [5];
  logic saw;

  always #5 clk = ~clk;

  psx_ddr_arbiter #(.PRIO_PORT0(1), .CNT_W(32)) dut (
    .i_clk(clk), .i_nRst(rst_n),
    .i_req0(req[0]), .i_write0(wr[0]), .i_size0(sz[0]), .i_adr0(adr[0]),
    .i_subadr0(sub[0]), .i_mask0(msk[0]), .i_data0(dat[0]),
    .i_req1(req[1]), .i_write1(wr[1]), .i_size1(sz[1]), .i_adr1(adr[1]),
    .i_subadr1(sub[1]), .i_mask1(msk[1]), .i_data1(dat[1]),
    .i_req2(req[2]), .i_write2(wr[2]), .i_size2(sz[2]), .i_adr2(adr[2]),
    .i_subadr2(sub[2]), .i_mask2(msk[2]), .i_data2(dat[2]),
    .o_ack0(ack0), .o_ack1(ack1), .o_ack2(ack2),
    .o_dataValid0(dv0), .o_dataValid1(dv1), .o_dataValid2(dv2),
    .o_readData(rdata), .o_command(cmd), .o_writeElseRead(wer),
    .o_commandSize(csz), .o_targetAddr(taddr), .o_subAddr(saddr),
    .o_writeMask(wmask), .o_dataClient(dcl),
`ifdef PSX_DDR_ARB_STATS_EN
    .o_grantCnt0(g0), .o_grantCnt1(g1), .o_grantCnt2(g2), .o_stallCnt(stall),
`endif
    .i_busyBridge(busy), .i_dataValidBridge(dvb), .i_dataBridge(dbr)
  );

  psx_ddr_arbiter #(.PRIO_PORT0(0), .CNT_W(32)) dut_rr (
    .i_clk(clk), .i_nRst(rst_n),
    .i_req0(req[0]), .i_write0(wr[0]), .i_size0(sz[0]), .i_adr0(adr[0]),
    .i_subadr0(sub[0]), .i_mask0(msk[0]), .i_data0(dat[0]),
    .i_req1(req[1]), .i_write1(wr[1]), .i_size1(sz[1]), .i_adr1(adr[1]),
    .i_subadr1(sub[1]), .i_mask1(msk[1]), .i_data1(dat[1]),
    .i_req2(req[2]), .i_write2(wr[2]), .i_size2(sz[2]), .i_adr2(adr[2]),
    .i_subadr2(sub[2]), .i_mask2(msk[2]), .i_data2(dat[2]),
    .o_ack0(r_ack0), .o_ack1(r_ack1), .o_ack2(r_ack2),
    .o_dataValid0(r_dv0), .o_dataValid1(r_dv1), .o_dataValid2(r_dv2),
    .o_readData(r_rdata), .o_command(r_cmd), .o_writeElseRead(r_wer),
    .o_commandSize(r_csz), .o_targetAddr(r_taddr), .o_subAddr(r_saddr),
    .o_writeMask(r_wmask), .o_dataClient(r_dcl),
`ifdef PSX_DDR_ARB_STATS_EN
    .o_grantCnt0(r_g0), .o_grantCnt1(r_g1), .o_grantCnt2(r_g2), .o_stallCnt(r_stall),
`endif
    .i_busyBridge(busy), .i_dataValidBridge(dvb), .i_dataBridge(dbr)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_in();
    req = '0; wr = '0; busy = 1'b0; dvb = 1'b0; dbr = '0;
    for (int i = 0; i < 3; i++) begin
      sz[i] = '0; adr[i] = '0; sub[i] = '0; msk[i] = '0; dat[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Wait (bounded) for an ack on either instance; port=-1 when none arrives.
  task automatic wait_ack(input bit use_rr, output int port, output int n);
    logic [2:0] v;
    port = -1; n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      v = use_rr ? {r_ack2, r_ack1, r_ack0} : {ack2, ack1, ack0};
      if (v != 3'b000) begin
        port = v[0] ? 0 : (v[1] ? 1 : 2);
        n = i + 1;
        break;
      end
    end
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    tick(); tick(); #1;
    // reset state
    chk("rst_cmd", cmd, 0);
    chk("rst_ack", {ack2, ack1, ack0}, 0);
    chk("rst_dv", {dv2, dv1, dv0}, 0);
    chk("rst_addr", taddr, 0);
    chk("rst_data", dcl, 0);
    rst_n = 1'b1;
    tick();

    // port 1 read, 6 busy cycles, then read data
    req[1] = 1'b1; wr[1] = 1'b0; sz[1] = 2'd1; adr[1] = 15'h0123;
    wait_ack(0, p, lat);
    chk("rd_grant", p, 1);
    chk("rd_cmd", cmd, 1);
    chk("rd_ack1", ack1, 1);
    chk("rd_addr", taddr, 15'h0123);
    chk("rd_size", csz, 2'd1);
    chk("rd_wel", wer, 0);
    req[1] = 1'b0; busy = 1'b1;
    tick(); #1;
    chk("rd_cmd_pulse", cmd, 0);
    for (int i = 0; i < 4; i++) tick();
    tick();
    busy = 1'b0; dvb = 1'b1; dbr = {32{8'hA5}};
    #1;
    chk("rd_dv1", dv1, 1);
    chk("rd_dv0", dv0, 0);
    chk("rd_dv2", dv2, 0);
    chk("rd_rdata", rdata, {32{8'hA5}});
    tick(); #1;
    chk("rd_dv_idle", {dv2, dv1, dv0}, 0);
    dvb = 1'b0;

    // port 2 write, then a pending port 1 read waits for busy to drop
    req[2] = 1'b1; wr[2] = 1'b1; sz[2] = 2'd2; sub[2] = 3'd3;
    msk[2] = 16'h0003; dat[2] = 256'hDEADBEEF; adr[2] = 15'h7ABC;
    wait_ack(0, p, lat);
    chk("wr_grant", p, 2);
    chk("wr_wel", wer, 1);
    chk("wr_size", csz, 2'd2);
    chk("wr_sub", saddr, 3'd3);
    chk("wr_mask", wmask, 16'h0003);
    chk("wr_data", dcl, 256'hDEADBEEF);
    chk("wr_addr", taddr, 15'h7ABC);
    req[2] = 1'b0; wr[2] = 1'b0; busy = 1'b1;
    req[1] = 1'b1; adr[1] = 15'h0010;
    tick();
    dvb = 1'b1; dbr = 256'h1234;
    #1;
    chk("wr_no_dv", {dv2, dv1, dv0}, 0);
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      saw = saw | cmd;
    end
    chk("wr_busy_nocmd", saw, 0);
    busy = 1'b0; dvb = 1'b0;
    wait_ack(0, p, lat);
    chk("wr_next_grant", p, 1);
    chk("wr_next_lat", lat, 2);
    chk("wr_next_addr", taddr, 15'h0010);
    req[1] = 1'b0;
    tick(); tick(); tick();

    // busy held in IDLE blocks the command; command follows the drop by one cycle
    busy = 1'b1; req[1] = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      saw = saw | cmd;
    end
    chk("busy_nocmd", saw, 0);
    busy = 1'b0;
    tick(); #1;
    chk("busy_drop_cmd", cmd, 1);
    chk("busy_drop_ack1", ack1, 1);
    req[1] = 1'b0;
    tick(); tick(); tick();

    // port-0 priority: port 0 drops after first ack -> 0,1,2,1,2
    do_reset();
    req = 3'b111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(0, p, lat);
      got[g] = p;
      if (g == 0) req[0] = 1'b0;
    end
    chk("prio_g0", got[0], 0);
    chk("prio_g1", got[1], 1);
    chk("prio_g2", got[2], 2);
    chk("prio_g3", got[3], 1);
    chk("prio_g4", got[4], 2);
    req = '0;
    tick(); tick(); tick();

    // full rotation, all three holding -> 0,1,2,0
    do_reset();
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wait_ack(1, p, lat);
      got[g] = p;
    end
    chk("rr_g0", got[0], 0);
    chk("rr_g1", got[1], 1);
    chk("rr_g2", got[2], 2);
    chk("rr_g3", got[3], 0);
    req = '0;
    tick(); tick(); tick();

    // reset during WAIT clears everything immediately
    req[1] = 1'b1; adr[1] = 15'h0055; sz[1] = 2'd1;
    wait_ack(0, p, lat);
    chk("mid_grant", p, 1);
    req[1] = 1'b0; busy = 1'b1;
    tick(); tick();
    rst_n = 1'b0; dvb = 1'b1; dbr = 256'hBEEF;
    #1;
    chk("mid_rst_cmd", cmd, 0);
    chk("mid_rst_addr", taddr, 0);
    chk("mid_rst_size", csz, 0);
    chk("mid_rst_dv", {dv2, dv1, dv0}, 0);
    tick();
    rst_n = 1'b1; dvb = 1'b0; busy = 1'b0; dbr = '0;
    tick();
    req[1] = 1'b1; req[2] = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_ack(0, p, lat);
      got[g] = p;
    end
    chk("post_g0", got[0], 1);
    chk("post_g1", got[1], 2);
    chk("post_g4", got[4], 1);
    req = '0;
    tick(); tick(); tick();
`ifdef PSX_DDR_ARB_STATS_EN
    #1;
    chk("cnt0", g0, 0);
    chk("cnt1", g1, 3);
    chk("cnt2", g2, 2);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
